// File: rtl/background_frame_scheduler_pkg.sv
// background_frame_scheduler_pkg: shared PPU constants, FSM encoding and scroll helpers
package background_frame_scheduler_pkg;

    localparam int TILES_X_DEF  = 32;
    localparam int TILES_Y_DEF  = 30;
    localparam int TILE_PIX_DEF = 8;

    localparam logic [15:0] NT_BASE   = 16'h2000;
    localparam logic [15:0] NT_STRIDE = 16'h0400;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_ADVANCE = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    // Rows 30..31 do not exist in a nametable, so such a scroll starts at row 0
    function automatic logic [4:0] wrap_ty(input logic [4:0] ty);
        return (ty >= 5'd30) ? 5'd0 : ty;
    endfunction

endpackage

// File: rtl/background_frame_scheduler_addr_calc.sv
// bg_scroll_addr_calc: maps a screen tile plus coarse scroll to its nametable entry address
module bg_scroll_addr_calc
    import background_frame_scheduler_pkg::*;
(
    input  logic [4:0]  scr_col_i,
    input  logic [4:0]  scr_row_i,
    input  logic [4:0]  scroll_tx_i,
    input  logic [4:0]  scroll_ty_i,
    input  logic [1:0]  nt_select_i,
    output logic [15:0] base_addr_o,
    output logic [15:0] start_addr_o
);

    logic [5:0] sum_x;
    logic [5:0] sum_y;
    logic [4:0] sy;
    logic       hflip;
    logic       vflip;
    logic [1:0] idx;

    // Crossing a nametable edge flips into the neighbouring table horizontally or vertically
    always_comb begin
        sum_x        = {1'b0, scr_col_i} + {1'b0, scroll_tx_i};
        sum_y        = {1'b0, scr_row_i} + {1'b0, scroll_ty_i};
        hflip        = sum_x[5];
        vflip        = sum_y >= 6'd30;
        sy           = vflip ? 5'(sum_y - 6'd30) : sum_y[4:0];
        idx          = nt_select_i ^ {vflip, hflip};
        base_addr_o  = NT_BASE + NT_STRIDE * {14'd0, idx};
        start_addr_o = base_addr_o + {6'd0, sy, 5'd0} + {11'd0, sum_x[4:0]};
    end

endmodule

// File: rtl/background_frame_scheduler.sv
// background_frame_scheduler: walks every screen tile of a frame and hands each one,
// with its scrolled nametable address, to the tile renderer one at a time.
module background_frame_scheduler
    import background_frame_scheduler_pkg::*;
#(
    parameter int TILES_X  = TILES_X_DEF,
    parameter int TILES_Y  = TILES_Y_DEF,
    parameter int TILE_PIX = TILE_PIX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        abort,
    input  logic [1:0]  nt_select,
    input  logic [4:0]  scroll_tx,
    input  logic [4:0]  scroll_ty,
    output logic        tile_start,
    input  logic        tile_done,
    output logic [15:0] nametable_base_addr,
    output logic [15:0] nametable_start_addr,
    output logic [7:0]  video_mem_row_start,
    output logic [7:0]  video_mem_col_start,
    output logic        busy,
    output logic        frame_done
);

    logic [2:0]  state_q, state_d;
    logic [1:0]  nt_q;
    logic [4:0]  tx_q, ty_q;
    logic [4:0]  col_q, col_d, row_q, row_d;
    logic [15:0] base_q, start_q;
    logic [15:0] base_c, start_c;
    logic [7:0]  row_pix_q, col_pix_q;
    logic        last_col, last_tile;

    assign last_col  = col_q == 5'(TILES_X - 1);
    assign last_tile = last_col && (row_q == 5'(TILES_Y - 1));
    assign col_d     = last_col ? 5'd0 : col_q + 5'd1;
    assign row_d     = last_col ? row_q + 5'd1 : row_q;

    bg_scroll_addr_calc u_calc (
        .scr_col_i   (col_q),
        .scr_row_i   (row_q),
        .scroll_tx_i (tx_q),
        .scroll_ty_i (ty_q),
        .nt_select_i (nt_q),
        .base_addr_o (base_c),
        .start_addr_o(start_c)
    );

    // Abort outranks every other transition, including a coincident tile_done
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = frame_start ? S_LOAD : S_IDLE;
            S_LOAD:    state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    state_d = tile_done ? S_ADVANCE : S_WAIT;
            S_ADVANCE: state_d = last_tile ? S_FINISH : S_LOAD;
            default:   state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            nt_q      <= '0;
            tx_q      <= '0;
            ty_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            start_q   <= '0;
            row_pix_q <= '0;
            col_pix_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && frame_start) begin
                nt_q  <= nt_select;
                tx_q  <= scroll_tx;
                ty_q  <= wrap_ty(scroll_ty);
                col_q <= '0;
                row_q <= '0;
            end
            if (state_q == S_LOAD && !abort) begin
                base_q    <= base_c;
                start_q   <= start_c;
                row_pix_q <= 8'(row_q * TILE_PIX);
                col_pix_q <= 8'(col_q * TILE_PIX);
            end
            if (state_q == S_ADVANCE && !abort && !last_tile) begin
                col_q <= col_d;
                row_q <= row_d;
            end
        end
    end

    assign tile_start           = state_q == S_ISSUE;
    assign frame_done           = state_q == S_FINISH;
    assign busy                 = state_q != S_IDLE;
    assign nametable_base_addr  = base_q;
    assign nametable_start_addr = start_q;
    assign video_mem_row_start  = row_pix_q;
    assign video_mem_col_start  = col_pix_q;

endmodule
